spi_target: RTL and testbench



---
 rtl/spi_target.sv | 178 +++++++++++++++++
 tb/tb_spi_target.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// SPI target endpoint: oversamples the SPI pins in the clk domain, shifts tx words out on
// miso and assembles mosi bits into rx words, supporting all four CPOL/CPHA modes.
module spi_target #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             spi_clk,
    input  logic             cs,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             underrun
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   cpol_q, cpol_d;
    logic                   cpha_q, cpha_d;
    logic [WIDTH-1:0]       tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0]       rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0]       rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic                   busy_q, busy_d;
    logic                   reload_pend_q, reload_pend_d;
    logic                   first_q, first_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_chg, lead_edge, trail_edge, sample_edge, shift_edge;
    logic load_word;

    // Synchronizers flush to the idle levels so reset never looks like a cs fall or a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= {SYNC_STAGES{cpol}};
            cs_sync_q   <= '1;
            mosi_sync_q <= '1;
            sclk_prev_q <= cpol;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_chg    = sclk_s ^ sclk_prev_q;
    assign lead_edge   = sclk_chg & (sclk_s != cpol_q);
    assign trail_edge  = sclk_chg & (sclk_s == cpol_q);
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            tx_sh_q       <= '1;
            rx_sh_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            bit_cnt_q     <= '0;
            busy_q        <= 1'b0;
            reload_pend_q <= 1'b0;
            first_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cpol_q        <= cpol_d;
            cpha_q        <= cpha_d;
            tx_sh_q       <= tx_sh_d;
            rx_sh_q       <= rx_sh_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            bit_cnt_q     <= bit_cnt_d;
            busy_q        <= busy_d;
            reload_pend_q <= reload_pend_d;
            first_q       <= first_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cpol_d        = cpol_q;
        cpha_d        = cpha_q;
        tx_sh_d       = tx_sh_q;
        rx_sh_d       = rx_sh_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        bit_cnt_d     = bit_cnt_q;
        busy_d        = busy_q;
        reload_pend_d = reload_pend_q;
        first_d       = first_q;
        load_word     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!cs_s) begin
                    state_d = LOAD;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                end
            end
            LOAD: begin
                if (cs_s) begin
                    state_d = IDLE;
                end else begin
                    load_word     = 1'b1;
                    bit_cnt_d     = '0;
                    busy_d        = 1'b1;
                    reload_pend_d = 1'b0;
                    // In CPHA=1 the MSB is already on miso, so the first shift edge must not shift.
                    first_d       = cpha_q;
                    state_d       = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_s) begin
                    state_d       = IDLE;
                    busy_d        = 1'b0;
                    reload_pend_d = 1'b0;
                    first_d       = 1'b0;
                end else if (sample_edge) begin
                    rx_sh_d = {rx_sh_q[WIDTH-2:0], mosi_s};
                    if (bit_cnt_q == CW'(WIDTH - 1)) begin
                        bit_cnt_d     = '0;
                        rx_data_d     = {rx_sh_q[WIDTH-2:0], mosi_s};
                        rx_valid_d    = 1'b1;
                        reload_pend_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (shift_edge) begin
                    if (reload_pend_q) begin
                        load_word     = 1'b1;
                        reload_pend_d = 1'b0;
                    end else if (first_q) begin
                        first_d = 1'b0;
                    end else begin
                        tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_word) begin
            tx_sh_d = tx_valid ? tx_data : '1;
        end
    end

    assign tx_ready = load_word & tx_valid;
    assign underrun = load_word & ~tx_valid;
    assign miso     = (state_q == SHIFT) ? tx_sh_q[WIDTH-1] : 1'b1;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: a bit-level SPI master drives randomized and directed
// transfers; expected words and pulse counts come from a transfer-level model of the target.
module tb_spi_target;
    localparam int W  = 8;
    localparam int SS = 2;
    localparam int H  = 5;

    logic         clk = 1'b0;
    logic         reset, cpol, cpha, spi_clk, cs, mosi, miso;
    logic [W-1:0] tx_data, rx_data;
    logic         tx_valid, tx_ready, rx_valid, busy, underrun;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_rdy    = 0;
    int           n_und    = 0;
    logic [W-1:0] tx_q[$];
    logic [W-1:0] rx_seen[$];

    always #5 clk = ~clk;

    spi_target #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk     (clk),
        .reset   (reset),
        .cpol    (cpol),
        .cpha    (cpha),
        .spi_clk (spi_clk),
        .cs      (cs),
        .mosi    (mosi),
        .miso    (miso),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .busy    (busy),
        .underrun(underrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Pulse monitor, sampled on the falling edge of clk.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_valid) rx_seen.push_back(rx_data);
            if (tx_ready) n_rdy++;
            if (underrun) n_und++;
            if (tx_ready || underrun)
                check_eq("rdy_und_exclusive", 32'(tx_ready & underrun), 32'd0);
        end
    end

    // Transmit source: a FIFO that pops one word per accepted handshake.
    initial begin
        tx_valid = 1'b0;
        tx_data  = '0;
        forever begin
            @(negedge clk);
            if (tx_ready && tx_valid) begin
                @(posedge clk);
                #1;
                if (tx_q.size() != 0) void'(tx_q.pop_front());
            end
            tx_valid = (tx_q.size() != 0);
            if (tx_valid) tx_data = tx_q[0];
            else          tx_data = '0;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One SPI transfer of nbits bits; rst_bit >= 0 pulses reset after that many bits.
    task automatic xfer(input logic p, input logic h, input logic [15:0] mv, input int nbits,
                        input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [W-1:0] w2,
                        input int nq, input int rst_bit);
        logic [W-1:0] words[3];
        logic [W-1:0] val;
        logic [15:0]  got, exp_m;
        int           nb, full, nload, exp_rdy, base_rdy, base_und;

        words[0] = w0;
        words[1] = w1;
        words[2] = w2;
        cpol = p;
        cpha = h;
        spi_clk = p;
        cs = 1'b1;
        mosi = 1'b1;
        tx_q.delete();
        for (int i = 0; i < nq; i++) tx_q.push_back(words[i]);
        clks(4);
        check_eq("miso_idle", 32'(miso), 32'd1);
        check_eq("busy_idle", 32'(busy), 32'd0);
        rx_seen.delete();
        base_rdy = n_rdy;
        base_und = n_und;
        nb = (rst_bit >= 0) ? rst_bit : nbits;

        cs = 1'b0;
        clks(SS + 6);
        got = '0;
        for (int j = 0; j < nb; j++) begin
            if (!h) begin
                mosi = mv[nbits-1-j];
                clks(H);
                spi_clk = ~p;
                got = {got[14:0], miso};
                clks(H);
                spi_clk = p;
            end else begin
                spi_clk = ~p;
                mosi = mv[nbits-1-j];
                clks(H);
                spi_clk = p;
                got = {got[14:0], miso};
                clks(H);
            end
        end

        if (rst_bit >= 0) begin
            reset = 1'b1;
            clks(2);
            check_eq("rst_miso", 32'(miso), 32'd1);
            check_eq("rst_rx_data", 32'(rx_data), 32'd0);
            check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
            check_eq("rst_tx_ready", 32'(tx_ready), 32'd0);
            check_eq("rst_underrun", 32'(underrun), 32'd0);
            check_eq("rst_busy", 32'(busy), 32'd0);
            cs = 1'b1;
            clks(2);
            reset = 1'b0;
            clks(SS + 4);
        end else begin
            clks(H);
            check_eq("busy_active", 32'(busy), 32'd1);
            cs = 1'b1;
            clks(SS + 4);
        end
        check_eq("miso_after_cs", 32'(miso), 32'd1);
        check_eq("busy_after_cs", 32'(busy), 32'd0);

        // Reference: one load at cs fall, plus one per completed word whose following shift edge occurs.
        full  = nb / W;
        nload = 1;
        for (int k = 1; k <= full; k++)
            if (h == 1'b0 || nb > k * W) nload++;
        exp_rdy = (nload < nq) ? nload : nq;
        exp_m = '0;
        for (int j = 0; j < nb; j++) begin
            val   = (j / W < nq) ? words[j/W] : '1;
            exp_m = {exp_m[14:0], val[W-1-(j%W)]};
        end

        check_eq("master_rx", 32'(got), 32'(exp_m));
        check_eq("rx_valid_count", 32'(rx_seen.size()), 32'(full));
        for (int k = 0; k < full && k < rx_seen.size(); k++)
            check_eq($sformatf("rx_word%0d", k), 32'(rx_seen[k]), 32'(mv[nbits-1-W*k -: W]));
        check_eq("tx_ready_count", 32'(n_rdy - base_rdy), 32'(exp_rdy));
        check_eq("underrun_count", 32'(n_und - base_und), 32'(nload - exp_rdy));

        $display("xfer mode=%0d bits=%0d mosi=0x%0h nq=%0d rst_bit=%0d master_rx=0x%0h rx_words=%0d tx_ready=%0d underrun=%0d",
                 {p, h}, nb, mv, nq, rst_bit, got, rx_seen.size(), n_rdy - base_rdy, n_und - base_und);
    endtask

    initial begin
        reset   = 1'b1;
        cpol    = 1'b0;
        cpha    = 1'b0;
        spi_clk = 1'b0;
        cs      = 1'b1;
        mosi    = 1'b1;
        clks(3);
        check_eq("reset_miso", 32'(miso), 32'd1);
        check_eq("reset_tx_ready", 32'(tx_ready), 32'd0);
        check_eq("reset_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("reset_rx_data", 32'(rx_data), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_underrun", 32'(underrun), 32'd0);
        reset = 1'b0;
        clks(3);

        xfer(1'b0, 1'b0, 16'h00A5, 8,  8'h3C, 8'h00, 8'h00, 1, -1);
        xfer(1'b1, 1'b1, 16'h007E, 8,  8'h81, 8'h00, 8'h00, 1, -1);
        xfer(1'b0, 1'b1, 16'hC35A, 16, 8'h12, 8'h34, 8'h00, 2, -1);
        xfer(1'b1, 1'b0, 16'hC35A, 16, 8'h12, 8'h34, 8'h00, 2, -1);
        xfer(1'b0, 1'b0, 16'h00C3, 8,  8'h00, 8'h00, 8'h00, 0, -1);
        xfer(1'b0, 1'b0, 16'h0015, 5,  8'h5A, 8'h00, 8'h00, 1, -1);
        xfer(1'b0, 1'b0, 16'h0096, 8,  8'h69, 8'h00, 8'h00, 1, -1);
        xfer(1'b0, 1'b1, 16'h00B4, 8,  8'hE7, 8'h00, 8'h00, 1, 3);
        xfer(1'b0, 1'b1, 16'h004D, 8,  8'h2B, 8'h00, 8'h00, 1, -1);

        for (int t = 0; t < 14; t++) begin
            xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                 $urandom_range(1, 16), 8'($urandom), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 3), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
